// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; chained by the parent to form a DIGIT-bit ripple slice.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: WIDTH/DIGIT RUN cycles after accept, result held in DONE
// until out_ready; start is only taken in IDLE and is never queued.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSL = WIDTH / DIGIT;
  localparam int CW  = (clog2(NSL) > 0) ? clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, in_ready_q, out_valid_q;
  logic [DIGIT-1:0] slice_sum;
  logic [DIGIT:0]   chain;

  assign chain[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    fa_cell u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (chain[i]),
      .sum  (slice_sum[i]),
      .cout (chain[i+1])
    );
  end

  // Result bits enter at the top so the LSB slice ends up at bit 0 after NSL shifts.
  always_comb begin
    sum_d = sum_q >> DIGIT;
    sum_d[WIDTH-1 -: DIGIT] = slice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= cin ^ sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= chain[DIGIT];
          sum_q   <= sum_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q      <= chain[DIGIT];
            ovf_q       <= chain[DIGIT] ^ chain[DIGIT-1];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: four 8-bit instances (DIGIT 1,2,4,8) driven independently,
// results checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int inst, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s dut_digit_idx=%0d actual=0x%0h required=0x%0h", name, inst, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                                 input logic tsub);
    int   ua, ub, ci, sa, sb, r, sr;
    exp_t e;
    ua = int'(ta);
    ub = int'(tb);
    ci = int'(tcin);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (!tsub) begin
      r   = ua + ub + ci;
      sr  = sa + sb + ci;
      e.c = (r > 255);
    end else begin
      r   = ua - ub - ci;
      sr  = sa - sb - ci;
      e.c = (ua >= ub + ci);
    end
    e.s = r[7:0];
    e.v = (sr > 127) || (sr < -128);
    return e;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int D  = 1 << gi;
    localparam int NS = W / D;

    logic         rst_n, start, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    exp_t         q[$];
    bit           done = 1'b0;

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
    );

    always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
        chk("result_expected", gi, int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sum", gi, int'(sum), int'(e.s));
          chk("cout", gi, int'(cout), int'(e.c));
          chk("ovf", gi, int'(ovf), int'(e.v));
        end
      end
    end

    task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                      input logic tsub, input int hold, input bit early, input bit pulse);
      int         n;
      logic [7:0] s0;
      logic       c0, v0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("in_ready_idle", gi, int'(in_ready), 1);
      a     = ta;
      b     = tb;
      cin   = tcin;
      sub   = tsub;
      start = 1'b1;
      q.push_back(model(ta, tb, tcin, tsub));
      @(posedge clk);
      #1;
      start     = 1'b0;
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = early;
      if (pulse) begin
        start = 1'b1;
        a     = ~ta;
        b     = ~tb;
      end
      @(negedge clk);
      chk("in_ready_busy", gi, int'(in_ready), 0);
      n = 0;
      while (!out_valid && n < 40) begin
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n++;
      end
      chk("latency", gi, n, NS);
      s0 = sum;
      c0 = cout;
      v0 = ovf;
      if (!early) begin
        repeat (hold) begin
          @(negedge clk);
          chk("hold_valid", gi, int'(out_valid), 1);
          chk("hold_sum", gi, int'(sum), int'(s0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      start     = 1'b0;
      @(negedge clk);
      chk("valid_drop", gi, int'(out_valid), 0);
      chk("sum_kept", gi, int'(sum), int'(s0));
      chk("flags_kept", gi, int'({cout, ovf}), int'({c0, v0}));
    endtask

    task automatic mid_reset();
      @(negedge clk);
      a     = 8'hFF;
      b     = 8'hFF;
      cin   = 1'b1;
      sub   = 1'b0;
      start = 1'b1;
      q.push_back(model(8'hFF, 8'hFF, 1'b1, 1'b0));
      @(posedge clk);
      #1 start = 1'b0;
      repeat ((NS >= 3) ? 2 : 0) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_valid", gi, int'(out_valid), 0);
      chk("mr_sum", gi, int'(sum), 0);
      chk("mr_flags", gi, int'({cout, ovf}), 0);
      chk("mr_in_ready", gi, int'(in_ready), 1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (NS + 2) begin
        @(negedge clk);
        chk("mr_no_result", gi, int'(out_valid), 0);
      end
    endtask

    initial begin : driver
      rst_n     = 1'b0;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", gi, int'(in_ready), 1);
      chk("rst_valid", gi, int'(out_valid), 0);
      chk("rst_sum", gi, int'(sum), 0);
      chk("rst_flags", gi, int'({cout, ovf}), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      op(8'h10, 8'h20, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      op(8'hFF, 8'h01, 1'b0, 1'b0, 5, 1'b0, 1'b0);
      op(8'h3C, 8'h5A, 1'b1, 1'b0, 1, 1'b0, 1'b1);
      op(8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      op(8'h00, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0);
      mid_reset();
      op(8'd5, 8'd3, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      repeat (25) begin
        op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", gi, q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin : main
    int cyc;
    bit all_done;
    cyc      = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 20000) begin
      @(posedge clk);
      cyc++;
      all_done = g_dut[0].done && g_dut[1].done && g_dut[2].done && g_dut[3].done;
    end
    chk("all_drivers_done", 0, int'(all_done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
